// File: rtl/dds_i2s_pkg.sv
// Shared types and helpers for the WM8731 DSP-mode-A transmit path.
package dds_i2s_pkg;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_sample_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEFT,
    RIGHT,
    PAD
  } tx_state_e;

  // BCLK periods per frame, rounded to nearest.
  function automatic int unsigned frame_bclks(input int unsigned sys_clk,
                                              input int unsigned fs,
                                              input int unsigned div);
    return (sys_clk + div * fs) / (2 * div * fs);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles BCLK every BCLK_DIV clk cycles while enabled and
// flags the clk cycle in which BCLK is driven 1->0.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic bclk_o,
  output logic fall_event_o
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          terminal;

  always_comb begin
    terminal = enable_i && (cnt_q == CW'(BCLK_DIV - 1));
    cnt_d    = cnt_q;
    bclk_d   = bclk_q;
    if (!enable_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (terminal) begin
      cnt_d  = '0;
      bclk_d = !bclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o       = bclk_q;
  assign fall_event_o = terminal && bclk_q;

endmodule

// File: rtl/i2s_dsp_tx.sv
// DSP-mode-A master transmitter for the WM8731 DAC port with a one-deep
// stereo holding register behind a valid/ready handshake.
module i2s_dsp_tx
  import dds_i2s_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 50000000,
  parameter int SAMPLE_FREQ  = 96000,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_l_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_r_i,
  input  logic                    sample_valid_i,
  output logic                    sample_ready_o,
  output logic                    frame_start_o,
  output logic                    underrun_o,
  output logic                    FPGA_I2S_BCLK,
  output logic                    FPGA_I2S_DACLRC,
  output logic                    FPGA_I2S_DACDAT
);

  localparam int unsigned FRAME_BCLKS = frame_bclks(SYSTEM_CLOCK, SAMPLE_FREQ, BCLK_DIV);
  localparam int SLOT_W = $clog2(FRAME_BCLKS);
  localparam int SR_W   = 2 * SAMPLE_WIDTH;

  if (FRAME_BCLKS < 2 * SAMPLE_WIDTH + 1) begin : g_frame_too_short
    $error("FRAME_BCLKS too small to carry two channels plus sync slot");
  end
  if (SAMPLE_WIDTH != $bits(stereo_sample_t) / 2) begin : g_width_mismatch
    $error("SAMPLE_WIDTH must match the 16-bit codec word length");
  end

  tx_state_e          state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [SR_W-1:0]    shift_q, shift_d;
  stereo_sample_t     hold_q, hold_d;
  stereo_sample_t     last_q, last_d;
  logic               hold_full_q, hold_full_d;
  logic               lrc_q, lrc_d;
  logic               dat_q, dat_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q, underrun_d;
  logic               fall_event;
  logic               accept;
  logic               frame_load;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .bclk_o       (FPGA_I2S_BCLK),
    .fall_event_o (fall_event)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    last_d        = last_q;
    hold_full_d   = hold_full_q;
    lrc_d         = lrc_q;
    dat_d         = dat_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    frame_load    = 1'b0;
    accept        = sample_valid_i && !hold_full_q;

    if (!enable_i) begin
      state_d = IDLE;
      slot_d  = '0;
      shift_d = '0;
      lrc_d   = 1'b0;
      dat_d   = 1'b0;
    end else if (fall_event) begin
      if (state_q == IDLE || slot_q == SLOT_W'(FRAME_BCLKS - 1)) slot_d = '0;
      else                                                      slot_d = slot_q + 1'b1;

      if (slot_d == '0)                             state_d = SYNC;
      else if (slot_d <= SLOT_W'(SAMPLE_WIDTH))     state_d = LEFT;
      else if (slot_d <= SLOT_W'(2 * SAMPLE_WIDTH)) state_d = RIGHT;
      else                                          state_d = PAD;

      case (state_d)
        SYNC: begin
          lrc_d         = 1'b1;
          dat_d         = 1'b0;
          frame_start_d = 1'b1;
          frame_load    = 1'b1;
          if (hold_full_q) begin
            shift_d = hold_q;
            last_d  = hold_q;
          end else begin
            shift_d    = last_q;
            underrun_d = 1'b1;
          end
        end
        LEFT, RIGHT: begin
          lrc_d   = 1'b0;
          dat_d   = shift_q[SR_W-1];
          shift_d = shift_q << 1;
        end
        default: begin
          lrc_d = 1'b0;
          dat_d = 1'b0;
        end
      endcase
    end

    // A sample accepted on an underrunning frame start lands here for the next frame.
    if (accept) begin
      hold_d.l    = sample_l_i;
      hold_d.r    = sample_r_i;
      hold_full_d = 1'b1;
    end else if (frame_load && hold_full_q) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      last_q        <= '0;
      hold_full_q   <= 1'b0;
      lrc_q         <= 1'b0;
      dat_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      last_q        <= last_d;
      hold_full_q   <= hold_full_d;
      lrc_q         <= lrc_d;
      dat_q         <= dat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready_o  = !hold_full_q;
  assign frame_start_o   = frame_start_q;
  assign underrun_o      = underrun_q;
  assign FPGA_I2S_DACLRC = lrc_q;
  assign FPGA_I2S_DACDAT = dat_q;

endmodule

// File: tb/tb_i2s_dsp_tx.sv
// Directed bench for i2s_dsp_tx: a table of frame vectors plus hand-written
// sequences for handshake, disable and reset corner cases.
module tb_i2s_dsp_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [15:0] sample_l_i;
  logic [15:0] sample_r_i;
  logic        sample_valid_i;
  logic        sample_ready_o;
  logic        frame_start_o;
  logic        underrun_o;
  logic        bclk;
  logic        lrc;
  logic        dat;

  int n_vec = 0;
  int n_bad = 0;
  int n_acc = 0;

  i2s_dsp_tx dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable_i),
    .sample_l_i      (sample_l_i),
    .sample_r_i      (sample_r_i),
    .sample_valid_i  (sample_valid_i),
    .sample_ready_o  (sample_ready_o),
    .frame_start_o   (frame_start_o),
    .underrun_o      (underrun_o),
    .FPGA_I2S_BCLK   (bclk),
    .FPGA_I2S_DACLRC (lrc),
    .FPGA_I2S_DACDAT (dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        offer;
    logic [15:0] l;
    logic [15:0] r;
    logic        exp_under;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clk cycle; a pending offer that is accepted on this edge is withdrawn.
  task automatic step();
    logic acc;
    acc = sample_valid_i && sample_ready_o;
    @(posedge clk);
    #1;
    if (acc) begin
      sample_valid_i = 1'b0;
      n_acc++;
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    sample_l_i     = l;
    sample_r_i     = r;
    sample_valid_i = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    while (frame_start_o !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_frame_start: no frame_start_o within 2000 cycles");
    end
  endtask

  // Starts on a frame_start_o cycle, decodes one 520-cycle frame at BCLK rises.
  task automatic check_frame(input string name, input logic [31:0] exp_data);
    logic [31:0] data;
    logic        prev;
    int          lrc_hi;
    int          bad_bits;
    int          rises;
    data     = '0;
    lrc_hi   = 0;
    bad_bits = 0;
    rises    = 0;
    prev     = bclk;
    for (int i = 0; i < 520; i++) begin
      if (lrc === 1'b1) lrc_hi++;
      if (prev === 1'b0 && bclk === 1'b1) begin
        if (rises >= 1 && rises <= 32) data = {data[30:0], dat};
        else if (dat !== 1'b0) bad_bits++;
        rises++;
      end
      prev = bclk;
      step();
    end
    check({name, "_data"}, data, exp_data);
    check({name, "_lrc_cycles"}, lrc_hi, 8);
    check({name, "_sync_pad_zero"}, bad_bits, 0);
    check({name, "_bclk_rises"}, rises, 65);
    check({name, "_period"}, frame_start_o, 1'b1);
    $display("frame %s: data=%h lrc_cycles=%0d rises=%0d", name, data, lrc_hi, rises);
  endtask

  initial begin
    int n;
    int acc_before;

    vt[0] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 32'hA55A0F0F};
    vt[1] = '{1'b1, 16'h1234, 16'h5678, 1'b1, 32'hA55A0F0F};
    vt[2] = '{1'b1, 16'h7FFF, 16'h8000, 1'b0, 32'h12345678};
    vt[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h7FFF8000};
    vt[4] = '{1'b1, 16'h0000, 16'hFFFF, 1'b1, 32'h7FFF8000};
    vt[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0000FFFF};

    rst            = 1'b1;
    enable_i       = 1'b0;
    sample_l_i     = '0;
    sample_r_i     = '0;
    sample_valid_i = 1'b0;
    @(posedge clk);
    #1;
    steps(2);
    check("rst_ready", sample_ready_o, 1'b1);
    check("rst_frame_start", frame_start_o, 1'b0);
    check("rst_underrun", underrun_o, 1'b0);
    check("rst_bclk", bclk, 1'b0);
    check("rst_daclrc", lrc, 1'b0);
    check("rst_dacdat", dat, 1'b0);
    rst = 1'b0;

    // First sample, then enable: frame_start_o 8 cycles later.
    offer(16'hA55A, 16'h0F0F);
    step();
    check("t1_accept", n_acc, 1);
    check("t1_ready_drop", sample_ready_o, 1'b0);
    enable_i = 1'b1;
    wait_fs(n);
    check("t1_fs_latency", n, 8);
    check("t1_underrun", underrun_o, 1'b0);
    check("t1_daclrc", lrc, 1'b1);
    check("t1_bclk", bclk, 1'b0);
    check_frame("t1", 32'hA55A0F0F);

    for (int i = 0; i < 6; i++) begin
      check($sformatf("vec%0d_underrun", i), underrun_o, vt[i].exp_under);
      if (vt[i].offer) offer(vt[i].l, vt[i].r);
      check_frame($sformatf("vec%0d", i), vt[i].exp_data);
    end

    // Back-to-back offers: second waits with ready=0 until the next frame start.
    check("t3_underrun_pre", underrun_o, 1'b1);
    offer(16'h1111, 16'h2222);
    step();
    offer(16'h3333, 16'h4444);
    check("t3_ready_held", sample_ready_o, 1'b0);
    acc_before = n_acc;
    wait_fs(n);
    check("t3_fs_gap", n, 519);
    check("t3_not_taken_early", n_acc, acc_before);
    check("t3_ready_at_fs", sample_ready_o, 1'b1);
    check("t3_underrun_a", underrun_o, 1'b0);
    check_frame("t3_a", 32'h11112222);
    check("t3_underrun_b", underrun_o, 1'b0);
    check_frame("t3_b", 32'h33334444);

    // Offer lands on the very edge that starts a frame with the register empty.
    check("t4_underrun_pre", underrun_o, 1'b1);
    steps(519);
    check("t4_no_fs_yet", frame_start_o, 1'b0);
    acc_before = n_acc;
    offer(16'h5A5A, 16'hFFFF);
    step();
    check("t4_fs", frame_start_o, 1'b1);
    check("t4_underrun", underrun_o, 1'b1);
    check("t4_accepted", n_acc, acc_before + 1);
    check("t4_ready", sample_ready_o, 1'b0);
    check_frame("t4_repeat", 32'h33334444);
    check("t4_underrun_next", underrun_o, 1'b0);

    // Disable in slot 20 while a sample is held.
    offer(16'hC3C3, 16'h3C3C);
    step();
    steps(164);
    check("t5_dacdat_live", dat, 1'b1);
    check("t5_bclk_live", bclk, 1'b1);
    enable_i = 1'b0;
    step();
    check("t5_bclk_off", bclk, 1'b0);
    check("t5_daclrc_off", lrc, 1'b0);
    check("t5_dacdat_off", dat, 1'b0);
    check("t5_ready_held", sample_ready_o, 1'b0);
    steps(10);
    check("t5_idle_bclk", bclk, 1'b0);
    check("t5_idle_fs", frame_start_o, 1'b0);
    enable_i = 1'b1;
    wait_fs(n);
    check("t5_fs_latency", n, 8);
    check("t5_underrun", underrun_o, 1'b0);
    check_frame("t5", 32'hC3C3_3C3C);

    // Reset in slot 10 with a sample held: everything discarded.
    check("t6_underrun_pre", underrun_o, 1'b1);
    offer(16'h1357, 16'h2468);
    step();
    steps(84);
    check("t6_ready_pre", sample_ready_o, 1'b0);
    rst = 1'b1;
    step();
    check("t6_ready", sample_ready_o, 1'b1);
    check("t6_bclk", bclk, 1'b0);
    check("t6_daclrc", lrc, 1'b0);
    check("t6_dacdat", dat, 1'b0);
    check("t6_fs", frame_start_o, 1'b0);
    check("t6_underrun_rst", underrun_o, 1'b0);
    rst = 1'b0;
    wait_fs(n);
    check("t6_fs_latency", n, 8);
    check("t6_underrun", underrun_o, 1'b1);
    check_frame("t6", 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
